// File: rtl/proc_control.sv
// Control FSM for a small multicycle processor: sequences bus selects and
// register load enables for mv, mvi, add and sub over at most four cycles.
module proc_control (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [8:0] instr,
  output logic [9:0] bus_sel,
  output logic [7:0] r_in,
  output logic       a_in,
  output logic       g_in,
  output logic       add_sub,
  output logic       done,
  output logic       busy
);

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  localparam logic [9:0] SEL_DIN = 10'b0000000001;
  localparam logic [9:0] SEL_G   = 10'b1000000000;

  logic [1:0] state_q, state_d;
  logic [8:0] ir_q, ir_d;

  logic [2:0] op, rx, ry;
  assign op = ir_q[8:6];
  assign rx = ir_q[5:3];
  assign ry = ir_q[2:0];

  // Register Rk sits at bus_sel bit k+1, above din at bit 0.
  function automatic logic [9:0] regSel(input logic [2:0] r);
    return 10'b0000000010 << r;
  endfunction

  function automatic logic [7:0] regLoad(input logic [2:0] r);
    return 8'b00000001 << r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= T0;
      ir_q    <= 9'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // The instruction is captured only when a new one is accepted in T0.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      T0: begin
        if (run) begin
          ir_d    = instr;
          state_d = T1;
        end
      end
      T1: begin
        if (op == OP_ADD || op == OP_SUB) state_d = T2;
        else                              state_d = T0;
      end
      T2:      state_d = T3;
      default: state_d = T0;
    endcase
  end

  // Outputs depend on state and IR only, never on run or instr directly.
  always_comb begin
    bus_sel = SEL_DIN;
    r_in    = 8'b0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    add_sub = 1'b0;
    done    = 1'b0;
    busy    = (state_q != T0);
    case (state_q)
      T1: begin
        case (op)
          OP_MV: begin
            bus_sel = regSel(ry);
            r_in    = regLoad(rx);
            done    = 1'b1;
          end
          OP_MVI: begin
            r_in = regLoad(rx);
            done = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            bus_sel = regSel(rx);
            a_in    = 1'b1;
          end
          default: done = 1'b1;
        endcase
      end
      T2: begin
        bus_sel = regSel(ry);
        g_in    = 1'b1;
        add_sub = ir_q[6];
      end
      T3: begin
        bus_sel = SEL_G;
        r_in    = regLoad(rx);
        done    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_proc_control.sv
// Directed bench for proc_control: hand-computed expected outputs checked
// on every falling edge with immediate assertions.
module tb_proc_control;

  logic       clk;
  logic       reset;
  logic       run;
  logic [8:0] instr;
  logic [9:0] bus_sel;
  logic [7:0] r_in;
  logic       a_in;
  logic       g_in;
  logic       add_sub;
  logic       done;
  logic       busy;

  int compared   = 0;
  int mismatched = 0;

  localparam logic [9:0] DIN = 10'b0000000001;
  localparam logic [9:0] GSEL = 10'b1000000000;

  proc_control dut (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .instr   (instr),
    .bus_sel (bus_sel),
    .r_in    (r_in),
    .a_in    (a_in),
    .g_in    (g_in),
    .add_sub (add_sub),
    .done    (done),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change at the falling edge, well away from the sampling edge.
  task automatic applyStimulus(input logic rst, input logic go, input logic [8:0] ins);
    reset = rst;
    run   = go;
    instr = ins;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOne(input string tag, input string field,
                          input logic [9:0] obs, input logic [9:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s.%s observed=%b expected=%b", tag, field, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [9:0] eBus,
                             input logic [7:0] eR, input logic eA, input logic eG,
                             input logic eAs, input logic eDone, input logic eBusy);
    checkOne(tag, "bus_sel", bus_sel, eBus);
    checkOne(tag, "r_in", {2'b0, r_in}, {2'b0, eR});
    checkOne(tag, "a_in", {9'b0, a_in}, {9'b0, eA});
    checkOne(tag, "g_in", {9'b0, g_in}, {9'b0, eG});
    checkOne(tag, "add_sub", {9'b0, add_sub}, {9'b0, eAs});
    checkOne(tag, "done", {9'b0, done}, {9'b0, eDone});
    checkOne(tag, "busy", {9'b0, busy}, {9'b0, eBusy});
    compared++;
    assert ($countones(bus_sel) == 1) else begin
      mismatched++;
      $error("[TB] FAIL %s.onehot observed=%b expected=one bit set", tag, bus_sel);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput(tag, DIN, 8'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    applyStimulus(1'b1, 1'b1, 9'b001_011_000);
    tick();
    tick();
    checkIdle("reset_over_run");
    tick();
    checkIdle("reset_hold");

    applyStimulus(1'b0, 1'b0, 9'b0);
    tick();
    checkIdle("idle");

    // mvi R3,#din
    applyStimulus(1'b0, 1'b1, 9'b001_011_000);
    checkIdle("t0_run_no_comb_effect");
    tick();
    checkOutput("mvi_t1", DIN, 8'b00001000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 9'b0);
    tick();
    checkIdle("mvi_after");

    // mv R5,R2
    applyStimulus(1'b0, 1'b1, 9'b000_101_010);
    tick();
    checkOutput("mv_t1", 10'b0000001000, 8'b00100000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 9'b0);
    tick();
    checkIdle("mv_after");

    // sub R1,R6
    applyStimulus(1'b0, 1'b1, 9'b011_001_110);
    tick();
    checkOutput("sub_t1", 10'b0000000100, 8'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 9'b0);
    tick();
    checkOutput("sub_t2", 10'b0010000000, 8'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("sub_t3", GSEL, 8'b00000010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    checkIdle("sub_after");

    // add R0,R1 with a new run/instr pushed in during T2
    applyStimulus(1'b0, 1'b1, 9'b010_000_001);
    tick();
    checkOutput("ign_t1", 10'b0000000010, 8'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 9'b0);
    tick();
    checkOutput("ign_t2", 10'b0000000100, 8'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 9'b011_111_111);
    tick();
    checkOutput("ign_t3", GSEL, 8'b00000001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 9'b0);
    tick();
    checkIdle("ign_after");
    tick();
    checkIdle("ign_after2");

    // add R2,R3 aborted by reset in T2
    applyStimulus(1'b0, 1'b1, 9'b010_010_011);
    tick();
    checkOutput("rst_t1", 10'b0000001000, 8'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 9'b0);
    tick();
    checkOutput("rst_t2", 10'b0000010000, 8'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 9'b0);
    tick();
    checkIdle("rst_mid_op");
    applyStimulus(1'b0, 1'b0, 9'b0);
    tick();
    checkIdle("rst_no_done");

    // undefined opcode 111
    applyStimulus(1'b0, 1'b1, 9'b111_010_011);
    tick();
    checkOutput("undef_t1", DIN, 8'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 9'b0);
    tick();
    checkIdle("undef_after");

    // run held high: mvi R7, then mv R0,R7, then add R2,R2 back to back
    applyStimulus(1'b0, 1'b1, 9'b001_111_000);
    tick();
    checkOutput("b2b_mvi_t1", DIN, 8'b10000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 9'b000_000_111);
    tick();
    checkIdle("b2b_t0a");
    tick();
    checkOutput("b2b_mv_t1", 10'b0100000000, 8'b00000001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 9'b010_010_010);
    tick();
    checkIdle("b2b_t0b");
    tick();
    checkOutput("dbl_t1", 10'b0000001000, 8'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("dbl_t2", 10'b0000001000, 8'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("dbl_t3", GSEL, 8'b00000100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 9'b0);
    tick();
    checkIdle("final_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/proc_control.md
PROC_CONTROL -- requirements
Module: proc_control

Interface
REQ-001 The module SHALL have no parameters; the instruction word is fixed at 9 bits and bus select at 10 bits.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 run  input  1  start request; sampled only in state T0.
REQ-005 instr  input  9  instruction word {op[8:6], rx[5:3], ry[2:0]}.
REQ-006 bus_sel  output  10  one-hot bus select: bit0 din, bit(k+1) register Rk (k=0..7), bit9 G.
REQ-007 r_in  output  8  load enables for R0..R7; at most one bit high.
REQ-008 a_in  output  1  load enable for adder operand register A.
REQ-009 g_in  output  1  load enable for result register G.
REQ-010 add_sub  output  1  ALU op: 0 add, 1 subtract.
REQ-011 done  output  1  one-cycle pulse on the final cycle of each instruction.
REQ-012 busy  output  1  high in every state except T0.

Function
REQ-013 The FSM SHALL have four states (T0, T1, T2, T3) encoded internally; the block SHALL hold a 9-bit instruction register IR.
REQ-014 Opcodes: 000 mv Rx,Ry; 001 mvi Rx,#din; 010 add Rx,Ry; 011 sub Rx,Ry; 100-111 undefined.
REQ-015 T0: bus_sel=10'b0000000001, all enables 0, done 0; if run=1, IR<=instr and next state T1; else stay T0.
REQ-016 T1 mv: bus_sel=one-hot(Ry), r_in[Rx]=1, done=1, next T0.
REQ-017 T1 mvi: bus_sel=10'b0000000001 (din), r_in[Rx]=1, done=1, next T0.
REQ-018 T1 add/sub: bus_sel=one-hot(Rx), a_in=1, next T2.
REQ-019 T2 add/sub: bus_sel=one-hot(Ry), g_in=1, add_sub=IR[6], next T3.
REQ-020 T3 add/sub: bus_sel=10'b1000000000 (G), r_in[Rx]=1, done=1, next T0.
REQ-021 T1 undefined opcode: bus_sel=din, no enables, done=1, next T0 (no-op).
REQ-022 All outputs SHALL be combinational functions of state and IR only; run and instr SHALL NOT affect outputs combinationally.
REQ-023 bus_sel SHALL be exactly one-hot in every cycle; add_sub SHALL be 0 outside T2.
REQ-024 run asserted while busy SHALL be ignored; IR SHALL change only in T0 with run=1.
REQ-025 Rx=Ry SHALL be legal (e.g. add R2,R2 doubles R2); no special handling.
REQ-026 Latency: mv/mvi/undefined complete 2 cycles after run sampled (T0,T1); add/sub 4 cycles (T0..T3).
REQ-027 run held high continuously SHALL start a new instruction every time T0 is re-entered, with no idle gap beyond T0 itself.

Reset
REQ-028 reset=1 at a rising edge SHALL force state T0 and IR=9'b0 regardless of current state, including mid-instruction.
REQ-029 Reset SHALL have priority over run in the same cycle.
REQ-030 While in T0 after reset: bus_sel=10'b0000000001, r_in=0, a_in=0, g_in=0, add_sub=0, done=0, busy=0.

Verification
REQ-031 mvi: instr=9'b001_011_000, run pulse -> T1: bus_sel=10'b0000000001, r_in=8'b00001000, done=1; next cycle busy=0.
REQ-032 mv: instr=9'b000_101_010 -> T1: bus_sel=10'b0000001000, r_in=8'b00100000, done=1.
REQ-033 sub: instr=9'b011_001_110 -> T1 bus_sel=10'b0000000100, a_in=1; T2 bus_sel=10'b0010000000, g_in=1, add_sub=1; T3 bus_sel=10'b1000000000, r_in=8'b00000010, done=1.
REQ-034 Ignore-while-busy: start add (010_000_001), change instr and pulse run in T2 -> sequence completes unchanged, IR unchanged, exactly one done.
REQ-035 Reset mid-op: assert reset in T2 of add -> next cycle T0, all enables 0, done never pulses for that instruction.
REQ-036 Undefined: instr=9'b111_010_011 -> T1: r_in=0, a_in=0, g_in=0, done=1, bus_sel=10'b0000000001; one-hot check on bus_sel every cycle throughout.
